// File: rtl/pipe_pkg.sv
// Shared constants and types for the MIPS pipeline register-file slice.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/pipe_rf_scoreboard.sv
// Per-register pending-write counters, sticky over/underflow flag and RAW busy outputs.
// Optional debug counter tap under PIPE_REGFILE_DEBUG_PORT_EN.
module pipe_rf_scoreboard #(
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_ena,
  input  logic [ADDR_W-1:0] issue_waddr,
  input  logic              rf_wena,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic              sb_clear,
  input  logic [ADDR_W-1:0] rs_raddr,
  input  logic [ADDR_W-1:0] rt_raddr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              sb_overflow
`ifdef PIPE_REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [CNT_W-1:0]  dbg_pending
`endif
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [DEPTH];
  logic [DEPTH-1:0] inc, dec;
  logic [CNT_W-1:0] rs_left, rt_left;

  // One-hot issue/retire decode; $0 never participates.
  always_comb begin
    inc = '0;
    dec = '0;
    if (issue_ena && issue_waddr != '0) inc[issue_waddr] = 1'b1;
    if (rf_wena && rf_waddr != '0)      dec[rf_waddr]    = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
      sb_overflow <= 1'b0;
    end else if (sb_clear) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (inc[r] && !dec[r]) begin
          if (cnt[r] == CNT_MAX) sb_overflow <= 1'b1;
          else                   cnt[r] <= cnt[r] + 1'b1;
        end else if (dec[r] && !inc[r]) begin
          if (cnt[r] == '0) sb_overflow <= 1'b1;
          else              cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // A single write retiring this cycle is covered by the read bypass.
  assign rs_left = cnt[rs_raddr] - CNT_W'(dec[rs_raddr]);
  assign rt_left = cnt[rt_raddr] - CNT_W'(dec[rt_raddr]);
  assign rs_busy = (rs_raddr != '0) && (rs_left != '0);
  assign rt_busy = (rt_raddr != '0) && (rt_left != '0);

`ifdef PIPE_REGFILE_DEBUG_PORT_EN
  assign dbg_pending = cnt[dbg_raddr];
`endif
endmodule

// File: rtl/pipe_regfile.sv
// 32x32 MIPS register file with write-through read ports and pending-write scoreboard.
// Optional third read port and counter tap under PIPE_REGFILE_DEBUG_PORT_EN.
module pipe_regfile #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter int CNT_W  = pipe_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_wena,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rs_raddr,
  input  logic [ADDR_W-1:0] rt_raddr,
  output logic [DATA_W-1:0] rs_rdata,
  output logic [DATA_W-1:0] rt_rdata,
  input  logic              issue_ena,
  input  logic [ADDR_W-1:0] issue_waddr,
  input  logic              sb_clear,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              sb_overflow
`ifdef PIPE_REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [CNT_W-1:0]  dbg_pending
`endif
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(pipe_pkg::REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (rf_wena && rf_waddr != ZERO) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // $0 is hardwired; a same-cycle WB write is forwarded to the reader.
  assign rs_rdata = (rs_raddr == ZERO)                    ? '0       :
                    (rf_wena && rf_waddr == rs_raddr)     ? rf_wdata : regs[rs_raddr];
  assign rt_rdata = (rt_raddr == ZERO)                    ? '0       :
                    (rf_wena && rf_waddr == rt_raddr)     ? rf_wdata : regs[rt_raddr];
`ifdef PIPE_REGFILE_DEBUG_PORT_EN
  assign dbg_rdata = (dbg_raddr == ZERO)                  ? '0       :
                     (rf_wena && rf_waddr == dbg_raddr)   ? rf_wdata : regs[dbg_raddr];
`endif

  pipe_rf_scoreboard #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_ena   (issue_ena),
    .issue_waddr (issue_waddr),
    .rf_wena     (rf_wena),
    .rf_waddr    (rf_waddr),
    .sb_clear    (sb_clear),
    .rs_raddr    (rs_raddr),
    .rt_raddr    (rt_raddr),
    .rs_busy     (rs_busy),
    .rt_busy     (rt_busy),
    .sb_overflow (sb_overflow)
`ifdef PIPE_REGFILE_DEBUG_PORT_EN
    ,
    .dbg_raddr   (dbg_raddr),
    .dbg_pending (dbg_pending)
`endif
  );
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: bypass, $0 rules, scoreboard counting, saturation, clear, async reset.
module tb_pipe_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        rf_wena;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs_raddr, rt_raddr;
  logic [31:0] rs_rdata, rt_rdata;
  logic        issue_ena;
  logic [4:0]  issue_waddr;
  logic        sb_clear;
  logic        rs_busy, rt_busy, sb_overflow;
`ifdef PIPE_REGFILE_DEBUG_PORT_EN
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;
  logic [1:0]  dbg_pending;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pipe_regfile dut (
    .clk(clk), .rst(rst),
    .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs_raddr(rs_raddr), .rt_raddr(rt_raddr),
    .rs_rdata(rs_rdata), .rt_rdata(rt_rdata),
    .issue_ena(issue_ena), .issue_waddr(issue_waddr),
    .sb_clear(sb_clear),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .sb_overflow(sb_overflow)
`ifdef PIPE_REGFILE_DEBUG_PORT_EN
    , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dbg_pending(dbg_pending)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance through one rising edge; inputs then change 2ns after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rf_wena = 0; rf_waddr = 0; rf_wdata = 0;
    issue_ena = 0; issue_waddr = 0; sb_clear = 0;
  endtask

  initial begin
    rst = 1; rs_raddr = 0; rt_raddr = 0;
    idle();
    #3;
    for (int a = 0; a < 32; a++) begin
      rs_raddr = 5'(a); rt_raddr = 5'(31 - a);
      #0.1;
      chk("rst_rs", rs_rdata, 32'h0);
      chk("rst_rt", rt_rdata, 32'h0);
      chk("rst_busy", {30'd0, rs_busy, rt_busy}, 32'h0);
    end
    chk("rst_ovf", {31'd0, sb_overflow}, 32'h0);
    rst = 0;
    tick();

    // r5 write with same-cycle bypass, then stored value
    issue_ena = 1; issue_waddr = 5;
    tick();
    idle();
    rf_wena = 1; rf_waddr = 5; rf_wdata = 32'hDEADBEEF; rs_raddr = 5;
    #1;
    chk("byp_r5", rs_rdata, 32'hDEADBEEF);
    chk("byp_r5_busy", {31'd0, rs_busy}, 32'h0);
    tick();
    idle();
    #1;
    chk("stored_r5", rs_rdata, 32'hDEADBEEF);
    chk("r5_busy_after", {31'd0, rs_busy}, 32'h0);

    // $0 ignores writes and issues
    rf_wena = 1; rf_waddr = 0; rf_wdata = 32'hFFFFFFFF;
    issue_ena = 1; issue_waddr = 0; rs_raddr = 0;
    #1;
    chk("r0_byp", rs_rdata, 32'h0);
    chk("r0_busy", {31'd0, rs_busy}, 32'h0);
    tick();
    idle();
    #1;
    chk("r0_after", rs_rdata, 32'h0);
    chk("r0_busy_after", {31'd0, rs_busy}, 32'h0);
    chk("ovf_clean_a", {31'd0, sb_overflow}, 32'h0);

    // Two issues to r8, retire one at a time
    rt_raddr = 8;
    issue_ena = 1; issue_waddr = 8;
    #1;
    chk("r8_no_same_cyc", {31'd0, rt_busy}, 32'h0);
    tick();
    #1;
    chk("r8_busy_c1", {31'd0, rt_busy}, 32'h1);
    tick();
    idle();
    #1;
    chk("r8_busy_c2", {31'd0, rt_busy}, 32'h1);
    rf_wena = 1; rf_waddr = 8; rf_wdata = 32'h11111111;
    #1;
    chk("r8_wb1_busy", {31'd0, rt_busy}, 32'h1);
    chk("r8_wb1_data", rt_rdata, 32'h11111111);
    tick();
    rf_wdata = 32'h22222222;
    #1;
    chk("r8_wb2_busy", {31'd0, rt_busy}, 32'h0);
    chk("r8_wb2_data", rt_rdata, 32'h22222222);
    tick();
    idle();
    #1;
    chk("r8_cnt0_busy", {31'd0, rt_busy}, 32'h0);
    chk("r8_stored", rt_rdata, 32'h22222222);

    // Issue and retire r3 together while one write already pending
    rs_raddr = 3;
    issue_ena = 1; issue_waddr = 3;
    tick();
    rf_wena = 1; rf_waddr = 3; rf_wdata = 32'h33;
    #1;
    chk("r3_incdec_busy", {31'd0, rs_busy}, 32'h0);
    tick();
    idle();
    #1;
    chk("r3_held_busy", {31'd0, rs_busy}, 32'h1);
    rf_wena = 1; rf_waddr = 3; rf_wdata = 32'h34;
    tick();
    idle();
    #1;
    chk("r3_drained", {31'd0, rs_busy}, 32'h0);
    chk("ovf_clean_b", {31'd0, sb_overflow}, 32'h0);

    // Saturate r9
    rs_raddr = 9;
    issue_ena = 1; issue_waddr = 9;
    tick(); tick(); tick();
    #1;
    chk("r9_cnt3_ovf", {31'd0, sb_overflow}, 32'h0);
    chk("r9_busy", {31'd0, rs_busy}, 32'h1);
    tick();
    #1;
    chk("r9_sat_ovf", {31'd0, sb_overflow}, 32'h1);
    sb_clear = 1;
    tick();
    idle();
    #1;
    chk("r9_clr_busy", {31'd0, rs_busy}, 32'h0);
    chk("clr_keeps_ovf", {31'd0, sb_overflow}, 32'h1);

    // Async reset between edges
    rs_raddr = 5;
    #1;
    chk("r5_pre_rst", rs_rdata, 32'hDEADBEEF);
    rst = 1;
    #1;
    chk("async_rst_ovf", {31'd0, sb_overflow}, 32'h0);
    chk("async_rst_r5", rs_rdata, 32'h0);
    rst = 0;
    tick();

    // Retire with nothing pending is an error
    rf_wena = 1; rf_waddr = 7; rf_wdata = 32'h77;
    tick();
    idle();
    #1;
    chk("underflow_ovf", {31'd0, sb_overflow}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
